code_loader: RTL
================

# code_loader

Boot-time program loader that writes the CPU's code memory, acting as the writer side of the code-memory read port the core fetches from. It accepts a framed byte stream on a valid/ready interface (fed by the host-link receiver), assembles little-endian 32-bit instruction words, issues single-cycle writes to the code memory write port, and holds the core in reset until a complete, checksum-verified image has been written.

## Interface
- `CODE_WORDS`, 512: code memory depth in words; the maximum legal frame length.
- `ADDR_W`, `$clog2(CODE_WORDS)` = 9: code write address width.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT`, 1_000_000: maximum number of idle cycles allowed between bytes inside a frame.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the loader accepts `in_data` this cycle.
- `code_we` out 1: code memory write strobe, one-cycle pulse.
- `code_waddr` out `ADDR_W`: word address for the write.
- `code_wd` out 32: instruction word to write.
- `cpu_hold` out 1: while high, the core is held in reset (drives the core's active-low reset inverted).
- `load_done` out 1: the last frame loaded and verified.
- `load_error` out 1: the last frame failed. Sticky until the next SYNC byte is accepted.
- `words_loaded` out `ADDR_W+1`: number of words written in the current or last frame.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- Frame format: SYNC, LEN_LO, LEN_HI, then LEN×4 data bytes, then CSUM.
  - Data words are little-endian: the first byte goes to [7:0].
  - CSUM is the XOR of every byte after SYNC (the two LEN bytes plus all data bytes).
- The FSM has the following states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR.
- **IDLE:** `in_ready`=1. Non-SYNC bytes are consumed and discarded. On accepting SYNC:
  - clear the checksum, `words_loaded`, `load_done` and `load_error`;
  - set `cpu_hold`=1;
  - go to LEN_LO.
- **LEN_LO / LEN_HI:** latch the 16-bit LEN.
  - If LEN==0 or LEN>CODE_WORDS after LEN_HI, go to ERR.
  - Otherwise go to DATA with byte index 0.
- **DATA:** shift the accepted byte into the word register and increment the byte index (2 bits). On the 4th byte, go to WRITE.
- **WRITE:** lasts exactly one cycle with `in_ready`=0.
  - `code_we`=1, `code_waddr`=`words_loaded[ADDR_W-1:0]`, `code_wd`=the assembled word.
  - Then increment `words_loaded`.
  - Next state is CSUM if `words_loaded`+1==LEN, else DATA.
- **CSUM:** on accept, if the byte equals the running XOR go to DONE, else go to ERR.
- **DONE:** `load_done`=1 and `cpu_hold`=0. Behaves as IDLE: a new SYNC restarts the load and reasserts `cpu_hold`.
- **ERR:** `load_error`=1 and `cpu_hold` stays 1. Behaves as IDLE for SYNC detection. Words already written are not rolled back.
- **Timeout:** in LEN_LO, LEN_HI, DATA or CSUM, a counter increments every cycle without an accepted byte and clears on accept. Reaching TIMEOUT goes to ERR.
- A SYNC value arriving inside a frame is treated as ordinary data or length. There is no resynchronisation mid-frame.

## Timing
- **Reset values (asynchronous):**
  - state=IDLE, `in_ready`=1, `code_we`=0, `code_waddr`=0, `code_wd`=0, `cpu_hold`=1.
  - `load_done`=0, `load_error`=0, `words_loaded`=0, checksum=0, timeout counter=0.
- **Write latency:** the 4th data byte is accepted at edge k. `code_we`, `code_waddr` and `code_wd` are registered and valid during cycle k→k+1. `in_ready` is 0 in that same cycle. The next byte can be accepted at edge k+2 at the earliest.
- Peak throughput is 4 bytes per 5 cycles. All other states accept one byte per cycle.
- `cpu_hold` falls, and `load_done` rises, in the cycle after the CSUM byte is accepted at edge k (valid from k+1).
- `load_error` rises in the cycle after the failing condition is detected:
  - after the LEN_HI accept,
  - after the CSUM accept, or
  - on the edge where the timeout counter reaches TIMEOUT.
- **Reset mid-frame:** the loader returns immediately to reset values with `cpu_hold`=1. A partially written image stays in memory but is never released to the core.
- `code_we` is never asserted outside WRITE, and never more than LEN times per frame.
- `words_loaded` never exceeds CODE_WORDS.

## Test plan
- **Good 2-word frame:** A5, 02, 00, 03 00 A6 8B, 03 00 00 14, CSUM=02^00^03^00^A6^8B^03^00^00^14.
  - Two `code_we` pulses: addr 0 gets 32'h8BA60003, addr 1 gets 32'h14000003.
  - `load_done`=1, `cpu_hold` falls, `words_loaded`=2.
- **Bad checksum:** the same frame with CSUM^8'h01.
  - Both writes still occur.
  - `load_error`=1, `cpu_hold`=1, `load_done`=0.
- **Illegal length:**
  - LEN=0 → `load_error`=1, zero writes.
  - LEN=513 (01,02) → `load_error`=1, zero writes.
- **Timeout:** with TIMEOUT=16, stop sending after 2 data bytes.
  - `load_error` asserts 16 cycles after the last accept, with no write.
  - A following good frame then loads correctly and clears `load_error`.
- **Garbage and backpressure:**
  - 00, FF, 5A before SYNC are discarded with no state change.
  - `in_valid` held high through a WRITE: `in_ready`=0 for exactly one cycle and no byte is lost.
- **Reset mid-load:** assert `reset` after 6 data bytes.
  - All outputs return to reset values, `cpu_hold`=1.
  - A subsequent full frame loads with `words_loaded` counting from 0.

Source files
------------

// File: rtl/code_loader.sv
`timescale 1ns / 1ps
// code_loader: boot-time program loader for the CPU code memory.
// Accepts a framed byte stream (SYNC, LEN_LO, LEN_HI, LEN*4 data bytes, CSUM), assembles
// little-endian 32-bit words, writes them to code memory one word per single-cycle strobe,
// and keeps the core in reset until a complete, checksum-verified image has been written.
//
// Ports:
//   clk_i, reset_i      clock and asynchronous active-high reset
//   in_data_i/valid_i   stream byte and its valid flag
//   in_ready_o          byte accepted on a rising edge where valid && ready
//   code_we_o           one-cycle write strobe to code memory
//   code_waddr_o        word address of the write
//   code_wd_o           instruction word to write
//   cpu_hold_o          high holds the core in reset
//   load_done_o         last frame loaded and verified
//   load_error_o        last frame failed (sticky until the next accepted SYNC)
//   words_loaded_o      words written in the current or last frame
module code_loader #(
  parameter int unsigned CodeWords = 512,
  parameter int unsigned AddrW     = $clog2(CodeWords),
  parameter logic [7:0]  SyncByte  = 8'hA5,
  parameter int unsigned Timeout   = 1_000_000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [7:0]       in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             code_we_o,
  output logic [AddrW-1:0] code_waddr_o,
  output logic [31:0]      code_wd_o,
  output logic             cpu_hold_o,
  output logic             load_done_o,
  output logic             load_error_o,
  output logic [AddrW:0]   words_loaded_o
);

  localparam int unsigned TmoW = $clog2(Timeout + 1);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              code_we_q, code_we_d;
  logic [AddrW-1:0]  code_waddr_q, code_waddr_d;
  logic [31:0]       code_wd_q, code_wd_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic [AddrW:0]    words_q, words_d;
  logic [7:0]        csum_q, csum_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [15:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;

  logic        accept;
  logic [15:0] len_full;
  logic        in_frame;

  assign accept   = in_valid_i && in_ready_q;
  assign len_full = {in_data_i, len_q[7:0]};
  // States in which a stalled sender is timed out.
  assign in_frame = (state_q == StLenLo) || (state_q == StLenHi) ||
                    (state_q == StData)  || (state_q == StCsum);

  always_comb begin
    state_d      = state_q;
    in_ready_d   = 1'b1;
    code_we_d    = 1'b0;
    code_waddr_d = code_waddr_q;
    code_wd_d    = code_wd_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    words_d      = words_q;
    csum_d       = csum_q;
    tmo_d        = '0;
    len_d        = len_q;
    word_d       = word_q;
    idx_d        = idx_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        // Non-SYNC bytes are swallowed; a SYNC always restarts a load.
        if (accept && (in_data_i == SyncByte)) begin
          state_d      = StLenLo;
          csum_d       = '0;
          words_d      = '0;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          cpu_hold_d   = 1'b1;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = in_data_i;
          csum_d     = csum_q ^ in_data_i;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d  = len_full;
          csum_d = csum_q ^ in_data_i;
          if ((len_full == 16'd0) || ({1'b0, len_full} > 17'(CodeWords))) begin
            state_d      = StErr;
            load_error_d = 1'b1;
          end else begin
            state_d = StData;
            idx_d   = 2'd0;
          end
        end
      end
      StData: begin
        if (accept) begin
          // First byte of a word ends up in [7:0] after four right shifts.
          word_d = {in_data_i, word_q[31:8]};
          csum_d = csum_q ^ in_data_i;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d      = StWrite;
            in_ready_d   = 1'b0;
            code_we_d    = 1'b1;
            code_waddr_d = words_q[AddrW-1:0];
            code_wd_d    = {in_data_i, word_q[31:8]};
          end
        end
      end
      StWrite: begin
        words_d = words_q + 1'b1;
        if ((17'(words_q) + 17'd1) == {1'b0, len_q}) begin
          state_d = StCsum;
        end else begin
          state_d = StData;
        end
      end
      StCsum: begin
        if (accept) begin
          if (in_data_i == csum_q) begin
            state_d     = StDone;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d      = StErr;
            load_error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Idle-cycle counter; the edge on which it would reach Timeout aborts the frame.
    if (in_frame && !accept) begin
      if (tmo_q == TmoW'(Timeout - 1)) begin
        state_d      = StErr;
        load_error_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b1;
      code_we_q    <= 1'b0;
      code_waddr_q <= '0;
      code_wd_q    <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      words_q      <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      len_q        <= '0;
      word_q       <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      code_we_q    <= code_we_d;
      code_waddr_q <= code_waddr_d;
      code_wd_q    <= code_wd_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      words_q      <= words_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      len_q        <= len_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign code_we_o      = code_we_q;
  assign code_waddr_o   = code_waddr_q;
  assign code_wd_o      = code_wd_q;
  assign cpu_hold_o     = cpu_hold_q;
  assign load_done_o    = load_done_q;
  assign load_error_o   = load_error_q;
  assign words_loaded_o = words_q;

endmodule
